// File: rtl/ecc_ladder_ctrl.sv
// ecc_ladder_ctrl: Montgomery-ladder sequencer driving the ECC core array (scan, per-phase restart, swap controls, done collection).
// Optional DONE_TIMEOUT_EN adds a per-phase cycle limit that aborts with a sticky error.
module ecc_ladder_ctrl #(
    parameter int KEY_W   = 163,
    parameter int NCORES  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [KEY_W-1:0]  i_key,
    input  logic [NCORES-1:0] i_core_done,
    output logic              o_core_rst,
    output logic              o_core_enable,
    output logic              o_swap1,
    output logic              o_swap2,
    output logic [1:0]        o_phase,
    output logic [7:0]        o_bit_idx,
    output logic              o_busy,
    output logic              o_finish,
    output logic              o_zero_key,
    output logic              o_error
);
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_PREP, S_RUN, S_NEXT, S_FINISH} state_t;
    state_t             r_state, w_next;
    logic [KEY_W-1:0]   r_key;
    logic [NCORES-1:0]  r_sticky;
    logic [7:0]         r_bit_idx;
    logic [1:0]         r_phase;
    logic               r_swap1, r_swap2, r_zero;
    logic               w_all, w_bit, w_last, w_timeout;
    logic [7:0]         w_dec;
    // done pulses arriving in the same cycle as the check still count
    assign w_all  = &(r_sticky | i_core_done);
    assign w_bit  = r_key[r_bit_idx];
    assign w_last = r_bit_idx == 8'd0;
    assign w_dec  = r_bit_idx - 8'd1;
`ifdef DONE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_error;
    assign w_timeout = !w_all && r_cnt == CNT_W'(TIMEOUT - 1);
    assign o_error   = r_error;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == S_PREP) r_cnt <= '0;
            if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE && i_start) r_error <= 1'b0;
            if (r_state == S_RUN && w_timeout) r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_error   = TIMEOUT < 0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_start ? S_SCAN : S_IDLE;
            S_SCAN:   w_next = w_bit ? S_PREP : (w_last ? S_FINISH : S_SCAN);
            S_PREP:   w_next = S_RUN;
            S_RUN:    w_next = w_all ? S_NEXT : (w_timeout ? S_FINISH : S_RUN);
            S_NEXT:   w_next = r_phase == 2'b11 ? S_FINISH : S_PREP;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key     <= '0;
            r_sticky  <= '0;
            r_bit_idx <= '0;
            r_phase   <= '0;
            r_swap1   <= 1'b0;
            r_swap2   <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_key     <= i_key;
                    r_bit_idx <= 8'(KEY_W - 1);
                end
                S_SCAN: begin
                    if (w_bit) r_phase <= 2'b01;
                    else if (w_last) r_zero <= 1'b1;
                    else r_bit_idx <= w_dec;
                end
                S_PREP: r_sticky <= '0;
                S_RUN:  r_sticky <= r_sticky | i_core_done;
                S_NEXT: if (r_phase != 2'b11) begin
                    if (!w_last) begin
                        r_bit_idx <= w_dec;
                        r_phase   <= 2'b10;
                        r_swap1   <= r_key[w_dec];
                        r_swap2   <= r_key[w_dec] ^ r_key[r_bit_idx];
                    end else r_phase <= 2'b11;
                end
                S_FINISH: begin
                    r_phase <= 2'b00;
                    r_swap1 <= 1'b0;
                    r_swap2 <= 1'b0;
                    r_zero  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign o_core_rst    = r_state == S_RUN;
    assign o_core_enable = r_state == S_RUN;
    assign o_swap1       = r_swap1;
    assign o_swap2       = r_swap2;
    assign o_phase       = r_phase;
    assign o_bit_idx     = r_bit_idx;
    assign o_busy        = r_state != S_IDLE;
    assign o_finish      = r_state == S_FINISH;
    assign o_zero_key    = r_zero;
endmodule

// File: tb/tb_ecc_ladder_ctrl.sv
// tb_ecc_ladder_ctrl: scoreboard bench; expected phases and finishes are queued by the stimulus and popped by a monitor.
module tb_ecc_ladder_ctrl;
    localparam int KW = 163;
    localparam int NC = 3;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [KW-1:0] key = '0;
    logic [NC-1:0] done;
    logic          core_rst, core_en, swap1, swap2, busy, finish, zero_key, error;
    logic [1:0]    phase;
    logic [7:0]    bit_idx;

    ecc_ladder_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_key(key), .i_core_done(done),
        .o_core_rst(core_rst), .o_core_enable(core_en), .o_swap1(swap1), .o_swap2(swap2),
        .o_phase(phase), .o_bit_idx(bit_idx), .o_busy(busy), .o_finish(finish),
        .o_zero_key(zero_key), .o_error(error)
    );

    always #5 clk = ~clk;

    typedef struct {logic [1:0] ph; logic [7:0] bi; logic s1; logic s2; logic cs; int rl;} ph_t;
    typedef struct {logic z; logic e;} fin_t;
    ph_t  q_ph[$];
    fin_t q_fin[$];
    ph_t  cur;
    fin_t f;
    int   dly[NC];
    int   mcnt = 0;
    int   tests = 0, fails = 0;
    logic prev_en = 1'b0, prev_fin = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // core model: core j pulses done in RUN cycle dly[j] (0 = never responds)
    always_comb begin
        for (int j = 0; j < NC; j++) done[j] = core_en && dly[j] != 0 && mcnt == dly[j];
    end

    always @(negedge clk) begin
        if (core_en) begin
            if (!prev_en) begin
                if (q_ph.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_phase: got phase %0d expected no phase", phase);
                    cur = '{2'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1};
                end else begin
                    cur = q_ph.pop_front();
                    chk("phase", phase, cur.ph);
                    chk("bit_idx", bit_idx, cur.bi);
                    chk("core_rst_run", core_rst, 1);
                    if (cur.cs) begin
                        chk("swap1", swap1, cur.s1);
                        chk("swap2", swap2, cur.s2);
                    end
                end
            end
            mcnt = prev_en ? mcnt + 1 : 1;
        end else if (prev_en) begin
            if (cur.rl > 0) chk("run_len", mcnt, cur.rl);
            mcnt = 0;
        end
        if (prev_fin) chk("finish_pulse", finish, 0);
        if (finish) begin
            if (q_fin.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_finish: got finish=1 expected 0");
            end else begin
                f = q_fin.pop_front();
                chk("zero_key", zero_key, f.z);
                chk("error", error, f.e);
                chk("phases_left", q_ph.size(), 0);
            end
        end
        prev_en  = core_en;
        prev_fin = finish;
    end

    task automatic run_op(input logic [KW-1:0] k, input bit glitch, output int lat);
        bit g = 0;
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy", busy, 1);
        lat = 1;
        while (!finish && lat < 4000) begin
            @(negedge clk);
            start = 1'b0;
            if (glitch && !g && core_en) begin
                key   = 163'd5;
                start = 1'b1;
                g     = 1;
            end
            lat++;
        end
        if (!finish) begin
            tests++;
            fails++;
            $display("FAIL finish_timeout: got no finish after %0d cycles expected finish", lat);
        end
        @(negedge clk);
    endtask

    int lat;

    initial begin
        dly = '{1, 1, 1};
        #12;
        chk("reset_outs", {core_rst, core_en, swap1, swap2, phase, bit_idx, busy, finish, zero_key, error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // zero key: full scan, no phases
        q_fin.push_back('{1'b1, 1'b0});
        run_op('0, 0, lat);
        chk("zero_latency_ok", lat <= KW + 2, 1);
        // key 1: init then final, done after 5 cycles
        dly = '{5, 5, 5};
        q_ph.push_back('{2'd1, 8'd0, 1'b0, 1'b0, 1'b1, 5});
        q_ph.push_back('{2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 5});
        q_fin.push_back('{1'b0, 1'b0});
        run_op(163'd1, 0, lat);
        // key 0b1011 with staggered done pulses and a start pulse during RUN
        dly = '{3, 7, 12};
        q_ph.push_back('{2'd1, 8'd3, 1'b0, 1'b0, 1'b1, 12});
        q_ph.push_back('{2'd2, 8'd2, 1'b0, 1'b1, 1'b1, 12});
        q_ph.push_back('{2'd2, 8'd1, 1'b1, 1'b1, 1'b1, 12});
        q_ph.push_back('{2'd2, 8'd0, 1'b1, 1'b0, 1'b1, 12});
        q_ph.push_back('{2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 12});
        q_fin.push_back('{1'b0, 1'b0});
        run_op(163'b1011, 1, lat);
        // top bit only: longest ladder, done in the first RUN cycle
        dly = '{1, 1, 1};
        q_ph.push_back('{2'd1, 8'd162, 1'b0, 1'b0, 1'b1, 1});
        for (int i = 161; i >= 0; i--) q_ph.push_back('{2'd2, 8'(i), 1'b0, i == 161, 1'b1, 1});
        q_ph.push_back('{2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1});
        q_fin.push_back('{1'b0, 1'b0});
        run_op(163'd1 << 162, 0, lat);
        // reset in the middle of RUN with one unresponsive core
        dly = '{2, 0, 2};
        q_ph.push_back('{2'd1, 8'd1, 1'b0, 1'b0, 1'b1, -1});
        @(negedge clk);
        key   = 163'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!core_en && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("run_reached", core_en, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset_outs", {core_rst, core_en, swap1, swap2, phase, bit_idx, busy, finish, zero_key, error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_queue_drained", q_ph.size(), 0);
        // recovery after abort
        dly = '{2, 2, 2};
        q_ph.push_back('{2'd1, 8'd0, 1'b0, 1'b0, 1'b1, 2});
        q_ph.push_back('{2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 2});
        q_fin.push_back('{1'b0, 1'b0});
        run_op(163'd1, 0, lat);
        repeat (3) @(negedge clk);
        chk("fin_queue_drained", q_fin.size(), 0);
        chk("idle_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
